// File: rtl/sevenseg_mux_counter.sv
// sevenseg_mux_counter
// Multiplexed seven-segment display driver with an integrated BCD up/down
// event counter. A refresh counter scans the digits one at a time. A tick
// prescaler advances a ripple-carry BCD count. Leading zeros can optionally
// be blanked.
//
// Parameters:
//   DIGITS        number of decimal digits (1..8)
//   REFRESH_DIV   clock cycles each digit stays selected (>=2)
//   COUNT_DIV     clock cycles per count tick (>=2)
//   BLANK_LEADING 1 blanks leading zeros, 0 shows every digit
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           count enable; low freezes the prescaler and the count
//   up           count direction, sampled on the tick cycle only
//   clear        synchronous clear of count and prescaler (beats a tick)
//   display      segments {a..g}, bit 6 = a, active-low
//   digit_select one-hot digit enable, active-high, bit 0 = least significant
//   count_bcd    current count, nibble i is digit i
//   wrap         one-cycle pulse when the count wraps in either direction

module sevenseg_mux_counter #(
  parameter int DIGITS        = 4,
  parameter int REFRESH_DIV   = 135000,
  parameter int COUNT_DIV     = 2700000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  output logic [6:0]            display,
  output logic [DIGITS-1:0]     digit_select,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap
);

  localparam int PW = $clog2(COUNT_DIV);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);
  localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(DIGITS - 1);

  logic [PW-1:0]         prescCnt_q, prescCnt_d;
  logic [RW-1:0]         refCnt_q, refCnt_d;
  logic [SW-1:0]         scanIdx_q, scanIdx_d;
  logic [4*DIGITS-1:0]   count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [6:0]            display_q, display_d;
  logic [DIGITS-1:0]     digitSel_q, digitSel_d;

  logic                  tick;
  logic [4*DIGITS-1:0]   rippled;
  logic                  carry;
  logic [3:0]            digitCur, digitNxt;
  logic [DIGITS-1:0]     leadZero;
  logic                  allZero;
  logic [3:0]            selNibble;
  logic                  selBlank;

  // Active-low segment patterns; anything outside 0..9 is dark.
  function automatic logic [6:0] segDecode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Tick prescaler: the tick fires on the terminal value and the
  // prescaler returns to zero on that same edge. Clear wins over enable.
  always_comb begin
    tick       = en && (prescCnt_q == PRESC_MAX);
    prescCnt_d = prescCnt_q;
    if (clear) begin
      prescCnt_d = '0;
    end else if (en) begin
      prescCnt_d = tick ? '0 : prescCnt_q + PW'(1);
    end
  end

  // Ripple carry/borrow through the digits. The carry into digit 0 is
  // always 1, so a carry that survives past the top digit marks a wrap.
  always_comb begin
    rippled  = count_q;
    carry    = 1'b1;
    digitCur = 4'd0;
    digitNxt = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digitCur = count_q[4*i +: 4];
      digitNxt = digitCur;
      if (carry) begin
        if (up) begin
          if (digitCur == 4'd9) begin
            digitNxt = 4'd0;
          end else begin
            digitNxt = digitCur + 4'd1;
            carry    = 1'b0;
          end
        end else begin
          if (digitCur == 4'd0) begin
            digitNxt = 4'd9;
          end else begin
            digitNxt = digitCur - 4'd1;
            carry    = 1'b0;
          end
        end
      end
      rippled[4*i +: 4] = digitNxt;
    end

    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = rippled;
      wrap_d  = carry;
    end
  end

  // Free-running scan: the index moves on each refresh-counter wrap and
  // ignores en/clear so the display never freezes.
  always_comb begin
    refCnt_d  = refCnt_q + RW'(1);
    scanIdx_d = scanIdx_q;
    if (refCnt_q == REF_MAX) begin
      refCnt_d  = '0;
      scanIdx_d = (scanIdx_q == SCAN_MAX) ? '0 : scanIdx_q + SW'(1);
    end
  end

  // A digit above zero is a leading zero when it and every higher digit
  // are zero; digit 0 is never flagged.
  always_comb begin
    leadZero = '0;
    allZero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      allZero     = allZero & (count_q[4*i +: 4] == 4'd0);
      leadZero[i] = allZero;
    end
  end

  // Pick the scanned digit and build the next segment/select pair from it,
  // so both output registers load from the same scan index.
  always_comb begin
    selNibble  = 4'd0;
    selBlank   = 1'b0;
    digitSel_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scanIdx_q == SW'(i)) begin
        selNibble     = count_q[4*i +: 4];
        selBlank      = leadZero[i];
        digitSel_d[i] = 1'b1;
      end
    end
    display_d = ((BLANK_LEADING != 0) && selBlank) ? 7'b1111111
                                                   : segDecode(selNibble);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescCnt_q <= '0;
      refCnt_q   <= '0;
      scanIdx_q  <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      display_q  <= 7'b1111111;
      digitSel_q <= '0;
    end else begin
      prescCnt_q <= prescCnt_d;
      refCnt_q   <= refCnt_d;
      scanIdx_q  <= scanIdx_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      display_q  <= display_d;
      digitSel_q <= digitSel_d;
    end
  end

  assign display      = display_q;
  assign digit_select = digitSel_q;
  assign count_bcd    = count_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_sevenseg_mux_counter.sv
// tb_sevenseg_mux_counter
// Self-checking bench for sevenseg_mux_counter with DIGITS=3,
// REFRESH_DIV=4, COUNT_DIV=5. A decimal reference model pushes the expected
// outputs for every clock edge into a queue. The queue is popped and
// compared half a cycle later. A table of stimulus segments also checks
// the count and the number of wrap pulses at the end of each segment.

module tb_sevenseg_mux_counter;

  localparam int DIGITS      = 3;
  localparam int REFRESH_DIV = 4;
  localparam int COUNT_DIV   = 5;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        clear;
  logic [6:0]  display;
  logic [2:0]  digit_select;
  logic [11:0] count_bcd;
  logic        wrap;

  typedef struct packed {
    logic [6:0]  disp;
    logic [2:0]  dsel;
    logic [11:0] cnt;
    logic        wrp;
  } outRec_t;

  typedef struct {
    logic        en;
    logic        up;
    logic        clear;
    int          cycles;
    logic [11:0] expCount;
    int          expWraps;
    string       name;
  } vec_t;

  outRec_t expQ[$];
  vec_t    vecs[16];
  int      errors = 0;
  int      checks = 0;
  int      wrapSeen = 0;

  int mCount = 0;
  int mPresc = 0;
  int mRef   = 0;
  int mScan  = 0;

  logic [6:0] segTab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010,
                               7'b0000110, 7'b1001100, 7'b0100100,
                               7'b0100000, 7'b0001111, 7'b0000000,
                               7'b0000100};

  sevenseg_mux_counter #(
    .DIGITS(DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .COUNT_DIV(COUNT_DIV),
    .BLANK_LEADING(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .up(up),
    .clear(clear),
    .display(display),
    .digit_select(digit_select),
    .count_bcd(count_bcd),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment pattern the display should show for digit idx of a decimal
  // count, blanking leading zeros above digit 0.
  function automatic logic [6:0] modelSeg(input int count, input int idx);
    int p;
    p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    if (idx > 0 && count < p) return 7'b1111111;
    return segTab[(count / p) % 10];
  endfunction

  function automatic logic [11:0] toBcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference model: on each rising edge compute what the outputs become
  // and queue it.
  always @(posedge clk) begin
    outRec_t e;
    if (rst) begin
      mCount = 0;
      mPresc = 0;
      mRef   = 0;
      mScan  = 0;
      e = '{disp: 7'b1111111, dsel: 3'b000, cnt: 12'h000, wrp: 1'b0};
    end else begin
      e.disp = modelSeg(mCount, mScan);
      e.dsel = 3'(1 << mScan);
      e.wrp  = 1'b0;
      if (clear) begin
        mCount = 0;
        mPresc = 0;
      end else if (en) begin
        if (mPresc == COUNT_DIV - 1) begin
          mPresc = 0;
          if (up) begin
            e.wrp  = (mCount == 999);
            mCount = (mCount + 1) % 1000;
          end else begin
            e.wrp  = (mCount == 0);
            mCount = (mCount + 999) % 1000;
          end
        end else begin
          mPresc++;
        end
      end
      e.cnt = toBcd(mCount);
      if (mRef == REFRESH_DIV - 1) begin
        mRef  = 0;
        mScan = (mScan + 1) % DIGITS;
      end else begin
        mRef++;
      end
    end
    expQ.push_back(e);
  end

  // Scoreboard: compare on the falling edge, away from the update edge.
  always @(negedge clk) begin
    outRec_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if ({display, digit_select, count_bcd, wrap} !== e) begin
        errors++;
        $display("[TB] FAIL scoreboard t=%0t got disp=%b sel=%b cnt=%h wrap=%b want disp=%b sel=%b cnt=%h wrap=%b",
                 $time, display, digit_select, count_bcd, wrap,
                 e.disp, e.dsel, e.cnt, e.wrp);
      end
    end
    if (wrap === 1'b1) wrapSeen++;
  end

  task automatic checkOutput(input string name, input logic [11:0] expCount,
                             input int expWraps);
    checks++;
    if (count_bcd !== expCount) begin
      errors++;
      $display("[TB] FAIL %s count got %h want %h", name, count_bcd, expCount);
    end
    checks++;
    if (wrapSeen != expWraps) begin
      errors++;
      $display("[TB] FAIL %s wraps got %0d want %0d", name, wrapSeen, expWraps);
    end
  endtask

  // Called at negedge+1: drive one segment, run it, check the end state.
  task automatic applyStimulus(input vec_t v);
    en       = v.en;
    up       = v.up;
    clear    = v.clear;
    wrapSeen = 0;
    repeat (v.cycles) @(negedge clk);
    #1;
    checkOutput(v.name, v.expCount, v.expWraps);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0,   12, 12'h000, 0, "idle_scan"};
    vecs[1]  = '{1'b1, 1'b1, 1'b0,   50, 12'h010, 0, "up_carry"};
    vecs[2]  = '{1'b1, 1'b0, 1'b0,   50, 12'h000, 0, "down_to_zero"};
    vecs[3]  = '{1'b1, 1'b0, 1'b0,    5, 12'h999, 1, "down_wrap"};
    vecs[4]  = '{1'b1, 1'b0, 1'b0,    5, 12'h998, 0, "down_998"};
    vecs[5]  = '{1'b1, 1'b1, 1'b0,   10, 12'h000, 1, "up_wrap_short"};
    vecs[6]  = '{1'b1, 1'b1, 1'b0,   12, 12'h002, 0, "up_partial"};
    vecs[7]  = '{1'b0, 1'b0, 1'b0,   20, 12'h002, 0, "hold"};
    vecs[8]  = '{1'b1, 1'b1, 1'b0,    3, 12'h003, 0, "resume"};
    vecs[9]  = '{1'b1, 1'b1, 1'b1,    1, 12'h000, 0, "clear"};
    vecs[10] = '{1'b1, 1'b0, 1'b0,    4, 12'h000, 0, "prime_tick"};
    vecs[11] = '{1'b1, 1'b0, 1'b1,    1, 12'h000, 0, "clear_vs_tick"};
    vecs[12] = '{1'b1, 1'b1, 1'b0,    5, 12'h001, 0, "restart"};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 4990, 12'h999, 0, "to_999"};
    vecs[14] = '{1'b1, 1'b1, 1'b0,    5, 12'h000, 1, "up_wrap"};
    vecs[15] = '{1'b1, 1'b1, 1'b0,  615, 12'h123, 0, "to_123"};

    rst   = 1'b1;
    en    = 1'b0;
    up    = 1'b1;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Asynchronous reset between edges: outputs must drop at once.
    rst = 1'b1;
    #1;
    checks++;
    if ({display, digit_select, count_bcd, wrap} !== {7'b1111111, 3'b000, 12'h000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset got disp=%b sel=%b cnt=%h wrap=%b want disp=1111111 sel=000 cnt=000 wrap=0",
               display, digit_select, count_bcd, wrap);
    end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    applyStimulus('{1'b1, 1'b1, 1'b0, 5, 12'h001, 0, "after_reset"});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
